// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: bus register offsets,
// STATUS/CTRL bit positions and the transmit FSM state encoding.
package uart_ctrl_pkg;

    // Byte offsets of the memory-mapped registers
    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    // STATUS register bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // CTRL register bit positions
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// Synchronous single-clock FIFO used as the UART transmit queue.
// Head data is presented combinationally on rdata; a push into a full FIFO is
// only taken when a pop happens in the same cycle, so no entry is overwritten.
module sync_fifo
    import uart_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller. The CPU pushes bytes through DATA,
// polls STATUS and enables transmission through CTRL; an FSM drains the FIFO
// one byte at a time using a start/busy handshake with the serializer.
// Optional feature macro: UART_TX_CTRL_IRQ_EN adds the irq output and the
// CTRL.irq_en bit; without it CTRL[1] is not stored and reads 0.
module uart_tx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy
`ifdef UART_TX_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    tx_state_t         state;
    logic              tx_en;
    logic              irq_en;
    logic              ovf;
    logic              wr_hit;
    logic              rd_hit;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       status_val;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    assign wr_hit   = bus_sel & bus_we;
    assign rd_hit   = bus_sel & bus_re;
    assign push_req = wr_hit & (bus_addr == ADDR_DATA);
    assign pop      = (state == ST_IDLE) & tx_en & ~fifo_empty & ~tx_busy;
    assign push_ok  = push_req & (~fifo_full | pop);

    // Only the low byte of write data carries meaning for any register
    assign unused_wdata = ^bus_wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .wdata (bus_wdata[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // CTRL register and sticky overflow flag (set on dropped byte, W1C via STATUS)
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (wr_hit && bus_addr == ADDR_CTRL) begin
                tx_en <= bus_wdata[CTRL_TX_EN];
            end
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end else if (wr_hit && bus_addr == ADDR_STATUS && bus_wdata[STAT_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef UART_TX_CTRL_IRQ_EN
    // Interrupt enable bit, stored only when the interrupt feature is built in
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
        end else if (wr_hit && bus_addr == ADDR_CTRL) begin
            irq_en <= bus_wdata[CTRL_IRQ_EN];
        end
    end

    // Level interrupt: queue drained and FSM idle, one cycle behind the condition
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & fifo_empty & (state == ST_IDLE);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // Transmit FSM: pop a byte, pulse tx_start, then track the serializer's busy window
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data  <= fifo_rdata;
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Assemble STATUS and select the register addressed by the current read
    always_comb begin
        status_val                = 32'(fifo_count) << STAT_CNT_LSB;
        status_val[STAT_FULL]     = fifo_full;
        status_val[STAT_EMPTY]    = fifo_empty;
        status_val[STAT_BUSY]     = (state != ST_IDLE);
        status_val[STAT_OVF]      = ovf;
        rd_val                    = 32'h0;
        case (bus_addr)
            ADDR_STATUS: rd_val = status_val;
            ADDR_CTRL: begin
                rd_val[CTRL_TX_EN]  = tx_en;
                rd_val[CTRL_IRQ_EN] = irq_en;
            end
            default: rd_val = 32'h0;
        endcase
    end

    // Read data register: captured on the read strobe, zero otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata <= 32'h0;
        end else if (rd_hit) begin
            bus_rdata <= rd_val;
        end else begin
            bus_rdata <= 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl. A small serializer model
// raises tx_busy for 10 cycles after each tx_start and logs every byte sent.
// Build with +define+UART_TX_CTRL_IRQ_EN to exercise the interrupt path.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_sel;
    logic        bus_we;
    logic        bus_re;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
`ifdef UART_TX_CTRL_IRQ_EN
    logic        irq;
`endif

    int          test_count = 0;
    int          fail_count = 0;
    int          busy_cnt = 0;
    logic [7:0]  sent_q [$];

    uart_tx_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy)
`ifdef UART_TX_CTRL_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Serializer model: log the byte on tx_start and stay busy for 10 cycles
    always @(posedge clk) begin
        if (tx_start === 1'b1) begin
            sent_q.push_back(tx_data);
            busy_cnt <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign tx_busy = (busy_cnt != 0);

    // Global watchdog so the run always ends
    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus cycle; called 1ns after a clock edge, returns 1ns after the next one
    task automatic apply_stimulus(input logic we, input logic re,
                                  input logic [3:0] addr, input logic [31:0] data);
        bus_sel   = 1'b1;
        bus_we    = we;
        bus_re    = re;
        bus_addr  = addr;
        bus_wdata = data;
        @(posedge clk);
        #1;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_wdata = 32'h0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr,
                             input logic [31:0] expected);
        apply_stimulus(1'b0, 1'b1, addr, 32'h0);
        check_output(tag, bus_rdata, expected);
    endtask

    task automatic wait_sent(input int n, input int budget, input string tag);
        int cyc = 0;
        while (sent_q.size() < n && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check_output(tag, 32'(sent_q.size()), 32'(n));
    endtask

    initial begin
        int cyc;
        reset     = 1'b1;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'h0;
        tick(3);

        // Reset state
        check_output("rst_tx_start", 32'(tx_start), 32'h0);
        check_output("rst_tx_data", 32'(tx_data), 32'h0);
        check_output("rst_rdata", bus_rdata, 32'h0);
        reset = 1'b0;
        tick(1);
        check_reg("rst_status", 4'h4, 32'h0000_0002);
        check_reg("rst_ctrl", 4'h8, 32'h0);
        check_reg("data_reads_zero", 4'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 4'hC, 32'hFFFF_FFFF);
        check_reg("unmapped_read", 4'hC, 32'h0);
        check_reg("ctrl_after_unmapped", 4'h8, 32'h0);

        // Test 1: single byte latency
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h1);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'h41);
        check_output("t1_no_start_yet", 32'(tx_start), 32'h0);
        tick(1);
        check_output("t1_start_n2", 32'(tx_start), 32'h1);
        check_output("t1_tx_data", 32'(tx_data), 32'h41);
        tick(1);
        check_output("t1_start_one_cycle", 32'(tx_start), 32'h0);
        tick(15);
        check_output("t1_sent_count", 32'(sent_q.size()), 32'h1);
        check_output("t1_sent_byte", 32'(sent_q[0]), 32'h41);
        check_reg("t1_status_idle", 4'h4, 32'h0000_0002);
        sent_q.delete();

        // Test 2: fill, overflow, drain in order, W1C
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 4'h0, 32'h30 + 32'(i));
        end
        check_reg("t2_status_full", 4'h4, 32'h0000_1001);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'h55);
        check_reg("t2_status_ovf", 4'h4, 32'h0000_1009);
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h1);
        wait_sent(16, 400, "t2_frames_seen");
        tick(30);
        check_output("t2_no_extra_frame", 32'(sent_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("t2_byte%0d", i), 32'(sent_q[i]), 32'h30 + 32'(i));
        end
        check_reg("t2_status_drained", 4'h4, 32'h0000_000A);
        apply_stimulus(1'b1, 1'b0, 4'h4, 32'h8);
        check_reg("t2_ovf_cleared", 4'h4, 32'h0000_0002);
        sent_q.delete();

        // Test 3: push into a full FIFO in the same cycle as a pop
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 4'h0, 32'h60 + 32'(i));
        end
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h1);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'h77);
        check_reg("t3_status_still_full", 4'h4, 32'h0000_1005);
        wait_sent(17, 500, "t3_frames_seen");
        tick(30);
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("t3_byte%0d", i), 32'(sent_q[i]), 32'h60 + 32'(i));
        end
        check_output("t3_last_byte", 32'(sent_q[16]), 32'h77);
        check_reg("t3_status_no_ovf", 4'h4, 32'h0000_0002);
        sent_q.delete();

        // Test 4: clear tx_en while the serializer is busy
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'hA1);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'hA2);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'hA3);
        cyc = 0;
        while (tx_busy !== 1'b1 && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check_output("t4_busy_rose", 32'(tx_busy), 32'h1);
        tick(3);
        check_reg("t4_status_wait_done", 4'h4, 32'h0000_0204);
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h0);
        tick(30);
        check_output("t4_one_frame_only", 32'(sent_q.size()), 32'h1);
        check_output("t4_first_byte", 32'(sent_q[0]), 32'hA1);
        check_reg("t4_status_two_left", 4'h4, 32'h0000_0200);
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h1);
        wait_sent(3, 200, "t4_resume_frames");
        tick(30);
        check_output("t4_second_byte", 32'(sent_q[1]), 32'hA2);
        check_output("t4_third_byte", 32'(sent_q[2]), 32'hA3);
        sent_q.delete();

        // Test 5: reset while waiting for busy
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 4'h0, 32'hB0 + 32'(i));
        end
        check_reg("t5_status_five", 4'h4, 32'h0000_0500);
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h1);
        cyc = 0;
        while (tx_start !== 1'b1 && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check_output("t5_start_seen", 32'(tx_start), 32'h1);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_output("t5_rst_tx_start", 32'(tx_start), 32'h0);
        check_output("t5_rst_tx_data", 32'(tx_data), 32'h0);
        reset = 1'b0;
        check_reg("t5_status_flushed", 4'h4, 32'h0000_0002);
        check_reg("t5_ctrl_cleared", 4'h8, 32'h0);
        tick(20);
        check_output("t5_no_more_frames", 32'(sent_q.size()), 32'h1);
        sent_q.delete();

`ifdef UART_TX_CTRL_IRQ_EN
        // Test 6: interrupt follows queue drain
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h3);
        check_reg("t6_ctrl_readback", 4'h8, 32'h3);
        tick(1);
        check_output("t6_irq_idle_empty", 32'(irq), 32'h1);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'hD1);
        apply_stimulus(1'b1, 1'b0, 4'h0, 32'hD2);
        check_output("t6_irq_low_queued", 32'(irq), 32'h0);
        wait_sent(2, 100, "t6_frames_seen");
        check_output("t6_irq_low_sending", 32'(irq), 32'h0);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 40) begin
            tick(1);
            cyc++;
        end
        check_output("t6_irq_high_done", 32'(irq), 32'h1);
        check_reg("t6_status_idle", 4'h4, 32'h0000_0002);
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h1);
        tick(1);
        check_output("t6_irq_cleared", 32'(irq), 32'h0);
`else
        // Without the interrupt feature CTRL[1] is not stored
        apply_stimulus(1'b1, 1'b0, 4'h8, 32'h3);
        check_reg("t6_ctrl_no_irq_en", 4'h8, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
